branch_resolve: RTL

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_pkg.sv | 15 +
 rtl/branch_resolve_cond.sv | 21 ++
 rtl/branch_resolve.sv | 76 +++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution block.
// Branch offsets are in instruction words; INSTR_SHIFT turns them into bytes.
package branch_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CBZ  = 2'd1,
    CBNZ = 2'd2,
    B    = 2'd3
  } br_kind_e;

  localparam int N_DEFAULT   = 64;
  localparam int INSTR_SHIFT = 2;

endpackage

// File: rtl/branch_resolve_cond.sv
// Combinational taken decision for the instruction sitting in M.
module branch_cond
  import branch_pkg::*;
(
  input  logic     valid,
  input  br_kind_e kind,
  input  logic     zero,
  output logic     take
);

  always_comb begin
    take = 1'b0;
    case (kind)
      B:       take = valid;
      CBZ:     take = valid & zero;
      CBNZ:    take = valid & ~zero;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Two-stage (E, M) branch resolution: target computed on E->M, redirect and
// flush issued from M registers only, plus a saturating taken-branch counter.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_D,
  input  br_kind_e         kind_D,
  input  logic [N-1:0]     PC_D,
  input  logic [N-1:0]     imm_D,
  input  logic             zero_E,
  output logic             PCSrc_F,
  output logic [N-1:0]     PCBranch_F,
  output logic             flush_DE,
  output logic [CNT_W-1:0] taken_cnt
);

  logic         valid_E;
  br_kind_e     kind_E;
  logic [N-1:0] PC_E;
  logic [N-1:0] imm_E;

  logic         valid_M;
  br_kind_e     kind_M;
  logic         zero_M;
  logic [N-1:0] target_M;

  logic         take_M;

  branch_cond u_cond (
    .valid (valid_M),
    .kind  (kind_M),
    .zero  (zero_M),
    .take  (take_M)
  );

  // A redirect out of M squashes whatever is entering E and M this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_E  <= 1'b0;
      kind_E   <= NONE;
      PC_E     <= '0;
      imm_E    <= '0;
      valid_M  <= 1'b0;
      kind_M   <= NONE;
      zero_M   <= 1'b0;
      target_M <= '0;
    end else begin
      valid_E  <= valid_D & ~PCSrc_F;
      kind_E   <= kind_D;
      PC_E     <= PC_D;
      imm_E    <= imm_D;
      valid_M  <= valid_E & ~PCSrc_F;
      kind_M   <= kind_E;
      zero_M   <= zero_E;
      target_M <= PC_E + (imm_E << INSTR_SHIFT);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      taken_cnt <= '0;
    end else if (PCSrc_F && (taken_cnt != '1)) begin
      taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

  assign PCSrc_F    = take_M;
  assign flush_DE   = take_M;
  assign PCBranch_F = valid_M ? target_M : '0;

endmodule
